// File: rtl/encoder_8_3_seq_pkg.sv
// Shared constants, FSM state type and one-hot helper for the sequential 8-to-3 encoder.
package encoder_8_3_seq_pkg;

  localparam int ENC_N = 8;
  localparam int ENC_W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } enc_state_e;

  function automatic logic [ENC_N-1:0] onehot(input logic [ENC_W-1:0] idx);
    onehot = {{(ENC_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/encoder_8_3_seq_prio_enc.sv
// Combinational highest-bit-wins priority encoder: bit 7 has top priority.
module prio_enc_8_3
  import encoder_8_3_seq_pkg::*;
(
  input  logic [ENC_N-1:0] req_i,
  output logic [ENC_W-1:0] idx_o,
  output logic             any_o
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx_o = {ENC_W{1'b0}};
    any_o = |req_i;
    for (int i = 0; i < ENC_N; i++) begin
      if (req_i[i]) begin
        idx_o = i[ENC_W-1:0];
      end else begin
        idx_o = idx_o;
      end
    end
  end

endmodule

// File: rtl/encoder_8_3_seq.sv
// Sequential 8-to-3 encoder: pending request register drained one index at a time
// through a valid/ready output stage, with a sticky duplicate-request flag.
module encoder_8_3_seq
  import encoder_8_3_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ENC_N-1:0] req_in,
  input  logic             load,
  output logic [ENC_W-1:0] y,
  output logic             valid,
  input  logic             ready,
  output logic [ENC_N-1:0] pend,
  output logic             dup_err
);

  enc_state_e       state_q;
  logic [ENC_W-1:0] y_q;
  logic             valid_q;
  logic [ENC_N-1:0] pend_q, pend_d;
  logic             dup_q, dup_d;

  logic [ENC_W-1:0] top_idx;
  logic             top_any;
  logic             issue;
  logic [ENC_N-1:0] clr;
  logic [ENC_N-1:0] held;

  prio_enc_8_3 u_prio (
    .req_i (pend_q),
    .idx_o (top_idx),
    .any_o (top_any)
  );

  // Issue decision and next pending/duplicate state; load is OR-ed after the clear so it wins.
  always_comb begin
    issue  = ((state_q == EMPTY) || ready) && top_any;
    clr    = issue ? onehot(top_idx) : {ENC_N{1'b0}};
    pend_d = (pend_q & ~clr) | (load ? req_in : {ENC_N{1'b0}});
    held   = valid_q ? onehot(y_q) : {ENC_N{1'b0}};
    dup_d  = dup_q | (load && ((req_in & (pend_q | held)) != {ENC_N{1'b0}}));
  end

  // Output FSM plus pending and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= {ENC_W{1'b0}};
      valid_q <= 1'b0;
      pend_q  <= {ENC_N{1'b0}};
      dup_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      dup_q  <= dup_d;
      case (state_q)
        EMPTY: begin
          if (issue) begin
            state_q <= HOLD;
            y_q     <= top_idx;
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (issue) begin
            y_q     <= top_idx;
            valid_q <= 1'b1;
          end else if (ready) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign y       = y_q;
  assign valid   = valid_q;
  assign pend    = pend_q;
  assign dup_err = dup_q;

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Self-checking bench for encoder_8_3_seq: directed scenarios, full req_in sweep and random traffic.
module tb_encoder_8_3_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic       load;
  logic [2:0] y;
  logic       valid;
  logic       ready;
  logic [7:0] pend;
  logic       dup_err;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0] m_pend;
  logic [2:0] m_y;
  logic       m_valid;
  logic       m_dup;

  encoder_8_3_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_in  (req_in),
    .load    (load),
    .y       (y),
    .valid   (valid),
    .ready   (ready),
    .pend    (pend),
    .dup_err (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int highest(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) begin
      if (v[b]) return b;
    end
    return -1;
  endfunction

  // One clock: drive inputs, advance model with the pre-edge values, compare after the edge.
  task automatic step(input logic rn, input logic ld, input logic [7:0] rq, input logic rd);
    logic [7:0] held;
    int h;
    rst_n  = rn;
    load   = ld;
    req_in = rq;
    ready  = rd;
    @(posedge clk);
    if (!rn) begin
      m_pend = 8'h00; m_y = 3'd0; m_valid = 1'b0; m_dup = 1'b0;
    end else begin
      held = m_valid ? (8'h01 << m_y) : 8'h00;
      if (ld && ((rq & (m_pend | held)) != 8'h00)) m_dup = 1'b1;
      h = highest(m_pend);
      if ((!m_valid || rd) && h >= 0) begin
        m_pend  = m_pend & ~(8'h01 << h);
        m_y     = 3'(h);
        m_valid = 1'b1;
      end else if (m_valid && rd) begin
        m_valid = 1'b0;
      end
      if (ld) m_pend = m_pend | rq;
    end
    #1;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("pend", 32'(pend), 32'(m_pend));
    chk("dup_err", 32'(dup_err), 32'(m_dup));
    if (m_valid) chk("y", 32'(y), 32'(m_y));
  endtask

  initial begin
    int exp_q[$];
    int got_q[$];
    int n;
    logic [7:0] v;

    rst_n = 1'b0; load = 1'b0; req_in = 8'h00; ready = 1'b0;
    m_pend = 8'h00; m_y = 3'd0; m_valid = 1'b0; m_dup = 1'b0;

    // Reset, with load/ready active to show they are ignored
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);

    // Two requests, ready held high
    step(1'b1, 1'b1, 8'b0010_0100, 1'b1);
    chk("t28_pend", 32'(pend), 32'h24);
    chk("t28_nogrant", 32'(valid), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t28_y5", 32'(y), 32'd5);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t28_y2", 32'(y), 32'd2);
    chk("t28_v2", 32'(valid), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t28_end", 32'(valid), 32'd0);
    chk("t28_pend0", 32'(pend), 32'd0);

    // All eight bits, no bubble
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1);
      chk("t29_v", 32'(valid), 32'd1);
      chk("t29_y", 32'(y), 32'(7 - i));
    end
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t29_end", 32'(valid), 32'd0);

    // Back-pressure holds y stable
    step(1'b1, 1'b1, 8'h81, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("t30_y7", 32'(y), 32'd7);
      chk("t30_pend", 32'(pend), 32'h01);
    end
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t30_y0", 32'(y), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t30_end", 32'(valid), 32'd0);

    // Re-request of the index currently held in y
    step(1'b1, 1'b1, 8'h10, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("t31_y4", 32'(y), 32'd4);
    step(1'b1, 1'b1, 8'h10, 1'b0);
    chk("t31_dup", 32'(dup_err), 32'd1);
    chk("t31_pend", 32'(pend), 32'h10);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t31_y4b", 32'(y), 32'd4);
    chk("t31_v", 32'(valid), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // Reset in mid-transfer
    step(1'b1, 1'b1, 8'h0F, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t32_y3", 32'(y), 32'd3);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t32_valid", 32'(valid), 32'd0);
    chk("t32_pend", 32'(pend), 32'd0);
    chk("t32_y", 32'(y), 32'd0);
    chk("t32_dup", 32'(dup_err), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("t32_nogrant", 32'(valid), 32'd0);

    // Load colliding with the issue of the same index: load wins
    step(1'b1, 1'b1, 8'h24, 1'b1);
    step(1'b1, 1'b1, 8'h20, 1'b1);
    chk("t19_y5", 32'(y), 32'd5);
    chk("t19_pend", 32'(pend), 32'h24);
    chk("t19_dup", 32'(dup_err), 32'd1);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    chk("t21_noop_y", 32'(y), 32'd5);
    chk("t21_noop_pend", 32'(pend), 32'h04);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Sweep of every request vector
    for (int val = 0; val < 256; val++) begin
      v = 8'(val);
      exp_q.delete();
      got_q.delete();
      for (int b = 7; b >= 0; b--) begin
        if (v[b]) exp_q.push_back(b);
      end
      step(1'b1, 1'b1, v, 1'b1);
      n = 0;
      while ((m_valid || m_pend != 8'h00) && n < 12) begin
        step(1'b1, 1'b0, 8'h00, 1'b1);
        if (valid) got_q.push_back(int'(y));
        n++;
      end
      if (n >= 12) chk("sweep_timeout", 32'(n), 32'd11);
      chk("sweep_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        chk("sweep_order", 32'(got_q[k]), 32'(exp_q[k]));
      end
      chk("sweep_dup", 32'(dup_err), 32'd0);
    end

    // Random traffic including occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) != 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 2) == 0),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/encoder_8_3_seq.md
ENCODER_8_3_SEQ -- requirements
Module: encoder_8_3_seq

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 req_in  input  8  request vector; any number of bits may be set.
REQ-005 load  input  1  when 1, req_in is merged into the pending register at the rising edge.
REQ-006 y  output  3  binary index of the granted request (inverse of the 3-to-8 one-hot decode).
REQ-007 valid  output  1  y holds a granted index.
REQ-008 ready  input  1  consumer accepts y; a transfer occurs when valid=1 and ready=1 at a rising edge.
REQ-009 pend  output  8  current pending register P.
REQ-010 dup_err  output  1  sticky flag: a load requested an index that was already pending or currently held in y.

Function
REQ-011 The pending register SHALL update as P_next = (P & ~clr) | (load ? req_in : 8'h00), where clr is the one-hot of the index issued this cycle, or 0 if none.
REQ-012 Priority: highest set bit of P wins (bit 7 highest, bit 0 lowest).
REQ-013 Output FSM, two states: EMPTY (valid=0) and HOLD (valid=1).
REQ-014 Issue condition: (state EMPTY, or HOLD with ready=1) and P != 0. On issue: y <= index of highest set bit of P; valid <= 1; that bit is cleared via clr.
REQ-015 In HOLD with ready=1 and P == 0: valid <= 0, next state EMPTY; y keeps its last value.
REQ-016 In HOLD with ready=0: y, valid and P bit selection SHALL be frozen; load still merges into P.
REQ-017 Latency: request bits loaded at edge n are visible on pend after edge n; the earliest valid=1 is after edge n+1 (2 cycles from load sample).
REQ-018 Back-to-back: with ready held 1 and P carrying k bits, k consecutive cycles of valid=1 SHALL occur with no bubble.
REQ-019 Simultaneous load and issue on the same index SHALL leave that bit set in P (load wins) and SHALL set dup_err.
REQ-020 dup_err SHALL be set when load=1 and (req_in & (P | (valid ? onehot(y) : 0))) != 0; it is cleared only by reset.
REQ-021 load with req_in = 0 SHALL be a no-op.
REQ-022 y SHALL be a pure function of P at issue time; no combinational path from req_in or ready to y or valid.

Reset
REQ-023 When rst_n=0 at a rising edge: P <= 0, y <= 3'b000, valid <= 0, dup_err <= 0, state <= EMPTY.
REQ-024 Reset mid-transfer SHALL discard the held y and all pending bits; no grant SHALL appear on the first edge after rst_n returns to 1.
REQ-025 load and ready SHALL be ignored while rst_n=0.

Structure
REQ-026 A shared package SHALL hold the constants ENC_N=8 and ENC_W=3 and the FSM state enum {EMPTY, HOLD}.
REQ-027 The combinational highest-bit priority encoder (8-bit in, 3-bit index plus any-flag out) SHALL be a sub-module named prio_enc_8_3; all registers live in encoder_8_3_seq.

Verification
REQ-028 Reset, then load=1 with req_in=8'b0010_0100 and ready=1 -> y=5 then y=2 on consecutive cycles with valid=1; valid=0 after; pend=0.
REQ-029 Load 8'hFF with ready=1 -> y sequence 7,6,5,4,3,2,1,0 over 8 consecutive cycles, no bubble.
REQ-030 Load 8'h81 with ready=0 for 4 cycles -> y=7 and valid=1 held stable, pend=8'h01; ready=1 -> y=0 next cycle, then valid=0.
REQ-031 Load 8'h10 while y=4 is held (ready=0) -> dup_err=1 and pend=8'h10; after ready=1, y=4 is issued a second time.
REQ-032 Load 8'h0F, then rst_n=0 for one edge while valid=1 -> valid=0, pend=0, y=0 after the edge; no grant on the following edge.
REQ-033 Sweep all 256 req_in values with single load and ready=1 -> issued indices equal the set bits of req_in in descending order, each exactly once, and dup_err stays 0.
